// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Default divider width/ratio and the high-phase length function live here.
package clkdiv_pkg;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_DIV_VAL = 64;
  localparam int MIN_DIV     = 2;

  // High-phase length H = ceil(N/2), written so N = 2^W-1 never needs an extra bit.
  function automatic logic [31:0] half_up(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/clkdiv_shadow.sv
// Divisor shadow register: validates loads, holds the pending value and
// hands it to the counter at the next period boundary.
module clkdiv_shadow
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             boundary,
  output logic [CNT_W-1:0] shadow,
  output logic             pend,
  output logic             apply,
  output logic             load_err
);

  logic accept;

  always_comb begin
    accept = div_load && (div_in >= CNT_W'(MIN_DIV));
    apply  = boundary && pend;
  end

  // A load landing on the boundary edge refills the shadow after the old value
  // has been consumed, so pend stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      pend     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= div_load && !accept;
      if (accept) begin
        shadow <= div_in;
        pend   <= 1'b1;
      end else if (apply) begin
        pend   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (N = 2..2^CNT_W-1, ~50% duty).
// Define CLKDIV_TICK_EN to add the per-period tick strobe output.
module clk_div_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_pend,
  output logic             load_err,
  output logic [CNT_W-1:0] div_cur,
  output logic             clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] n_q, n_nxt, h_nxt;
  logic [CNT_W-1:0] shadow;
  logic             boundary, apply, out_nxt;

  clkdiv_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .div_load (div_load),
    .div_in   (div_in),
    .boundary (boundary),
    .shadow   (shadow),
    .pend     (div_pend),
    .apply    (apply),
    .load_err (load_err)
  );

  // Boundary is the enabled 0 -> 1 step; a new divisor takes effect here so
  // the outgoing period always runs its full length.
  always_comb begin
    boundary = en && (cnt == '0);
    n_nxt    = apply ? shadow : n_q;
    cnt_nxt  = cnt;
    if (en) cnt_nxt = (cnt == n_q - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
    h_nxt    = CNT_W'(half_up(32'(n_nxt)));
    out_nxt  = (cnt_nxt != '0) && (cnt_nxt <= h_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      n_q     <= CNT_W'(DEF_DIV);
      clk_out <= 1'b0;
    end else if (en) begin
      cnt     <= cnt_nxt;
      n_q     <= n_nxt;
      clk_out <= out_nxt;
    end
  end

  assign div_cur = n_q;

`ifdef CLKDIV_TICK_EN
  always_ff @(posedge clk) begin
    if (rst) tick <= 1'b0;
    else     tick <= boundary;
  end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog against a period-position reference model.
module tb_clk_div_prog;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 64;
`ifdef CLKDIV_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, div_load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic div_pend, load_err, clk_out, tick_obs;
  logic [CNT_W-1:0] div_cur;

  int checks = 0, errors = 0, cyc = 0;

  // Model: position within the current period (1..N, 0 = not started since reset).
  int m_n = DEF_DIV, m_pos = 0, m_sh = 0;
  bit m_pend = 0, m_lerr = 0, m_tick = 0;

  always #5 clk = ~clk;

  clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .div_pend(div_pend), .load_err(load_err), .div_cur(div_cur), .clk_out(clk_out)
`ifdef CLKDIV_TICK_EN
    , .tick(tick_obs)
`endif
  );
`ifndef CLKDIV_TICK_EN
  assign tick_obs = 1'b0;
`endif

  wire [11:0] obs = {tick_obs, clk_out, div_pend, load_err, div_cur};

  function automatic logic [11:0] expv();
    logic c;
    c = (m_pos >= 1) && (m_pos <= (m_n + 1) / 2);
    return {TICK_ON & m_tick, c, m_pend, m_lerr, 8'(m_n)};
  endfunction

  task automatic model_edge(input bit e, input bit ld, input int d, input bit r);
    bit start;
    if (r) begin
      m_n = DEF_DIV; m_pos = 0; m_sh = 0; m_pend = 0; m_lerr = 0; m_tick = 0;
    end else begin
      m_lerr = ld && (d < 2);
      start  = e && (m_pos == 0 || m_pos == m_n);
      m_tick = start;
      if (start) begin
        if (m_pend) begin m_n = m_sh; m_pend = 0; end
        m_pos = 1;
      end else if (e) begin
        m_pos++;
      end
      if (ld && d >= 2) begin m_sh = d; m_pend = 1; end
    end
  endtask

  task automatic step(input bit e, input bit ld, input logic [7:0] d, input bit r);
    en = e; div_load = ld; div_in = d; rst = r;
    @(posedge clk);
    model_edge(e, ld, int'(d), r);
    #1;
    cyc++;
    div_load = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 0, 8'd0, 1);
    if (obs !== 12'h040) begin errors++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs, 12'h040); end
    checks++;
    step(0, 0, 8'd0, 0);
    if (obs !== expv()) begin errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
    checks++;
  endtask

  task automatic test_default();
    int hi = 0, lo = 0;
    bit ph = 0;
    for (int i = 0; i < 128; i++) begin
      step(1, 0, 8'd0, 0);
      if (obs !== expv()) begin errors++; $display("FAIL default cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
      if (i < 64) begin
        if (!ph && clk_out) hi++;
        else begin ph = 1; if (!clk_out) lo++; end
      end
    end
    if (hi != 32 || lo != 32) begin errors++; $display("FAIL default_duty hi=%0d lo=%0d exp 32/32", hi, lo); end
    checks++;
  endtask

  task automatic test_load_mid();
    int n = 0;
    bit found = 0;
    logic [9:0] pat;
    for (int i = 0; i < 10; i++) step(1, 0, 8'd0, 0);
    step(1, 1, 8'd5, 0);
    if (div_pend !== 1'b1 || div_cur !== 8'd64) begin errors++; $display("FAIL load_pend got=%b/%0d exp=1/64", div_pend, div_cur); end
    checks++;
    for (int i = 0; i < 80 && !found; i++) begin
      step(1, 0, 8'd0, 0);
      if (obs !== expv()) begin errors++; $display("FAIL load_mid cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
      n++;
      if (div_cur == 8'd5) found = 1;
    end
    if (!found || n != 54 || div_pend !== 1'b0) begin errors++; $display("FAIL load_latency got=%0d pend=%b exp=54 pend=0", n, div_pend); end
    checks++;
    pat[9] = clk_out;
    for (int i = 1; i < 10; i++) begin step(1, 0, 8'd0, 0); pat[9-i] = clk_out; end
    if (pat !== 10'b1110011100) begin errors++; $display("FAIL div5_pattern got=%b exp=%b", pat, 10'b1110011100); end
    checks++;
  endtask

  task automatic test_bad_load();
    for (int v = 0; v < 2; v++) begin
      step(1, 1, 8'(v), 0);
      if ({load_err, div_pend, div_cur} !== {1'b1, 1'b0, 8'd5}) begin errors++; $display("FAIL bad_load%0d got=%b%b/%0d exp=10/5", v, load_err, div_pend, div_cur); end
      checks++;
      step(1, 0, 8'd0, 0);
      if (obs !== expv()) begin errors++; $display("FAIL bad_load_after cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
    end
  endtask

  task automatic test_freeze();
    bit prev, found = 0;
    int hi = 1, lo = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      prev = clk_out;
      step(1, 0, 8'd0, 0);
      if (clk_out && !prev) found = 1;
    end
    step(1, 0, 8'd0, 0);
    if (clk_out) hi++;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'd0, 0);
      if (clk_out !== 1'b1 || obs !== expv()) begin errors++; $display("FAIL freeze_hold cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 8'd0, 0);
      if (clk_out) hi++; else found = 1;
    end
    lo = 1; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 8'd0, 0);
      if (!clk_out) lo++; else found = 1;
    end
    if (hi != 3 || lo != 2) begin errors++; $display("FAIL freeze_resume hi=%0d lo=%0d exp 3/2", hi, lo); end
    checks++;
  endtask

  task automatic test_back_to_back();
    bit prev, found = 0;
    logic [7:0] pat;
    for (int i = 0; i < 12 && !found; i++) begin
      prev = clk_out;
      step(1, 0, 8'd0, 0);
      if (clk_out && !prev) found = 1;
    end
    step(1, 1, 8'd7, 0);
    step(1, 1, 8'd9, 0);
    if (div_pend !== 1'b1 || obs !== expv()) begin errors++; $display("FAIL b2b_pend got=%h exp=%h", obs, expv()); end
    checks++;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1, 0, 8'd0, 0);
      if (div_cur != 8'd5) found = 1;
    end
    if (div_cur !== 8'd9) begin errors++; $display("FAIL b2b_last_wins got=%0d exp=9", div_cur); end
    checks++;
    pat[7] = clk_out;
    for (int i = 1; i < 8; i++) begin step(1, 0, 8'd0, 0); pat[7-i] = clk_out; end
    if (pat !== 8'b11111000) begin errors++; $display("FAIL div9_pattern got=%b exp=%b", pat, 8'b11111000); end
    checks++;
    step(1, 1, 8'd3, 0);
    step(1, 1, 8'd4, 0);
    if ({div_cur, div_pend, clk_out} !== {8'd3, 1'b1, 1'b1}) begin errors++; $display("FAIL same_edge_load got=%0d/%b/%b exp=3/1/1", div_cur, div_pend, clk_out); end
    checks++;
    for (int i = 0; i < 3; i++) step(1, 0, 8'd0, 0);
    if (div_cur !== 8'd4 || obs !== expv()) begin errors++; $display("FAIL same_edge_next got=%h exp=%h", obs, expv()); end
    checks++;
  endtask

  task automatic test_rst_pending();
    step(1, 1, 8'd3, 0);
    step(1, 0, 8'd0, 0);
    step(1, 0, 8'd0, 1);
    if (obs !== 12'h040) begin errors++; $display("FAIL rst_mid got=%h exp=%h", obs, 12'h040); end
    checks++;
    for (int i = 0; i < 80; i++) begin
      step(1, 0, 8'd0, 0);
      if (obs !== expv()) begin errors++; $display("FAIL rst_after cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
    end
    if (div_cur !== 8'd64) begin errors++; $display("FAIL rst_discard got=%0d exp=64", div_cur); end
    checks++;
  endtask

  task automatic test_extremes();
    bit prev_t = 0;
    step(1, 1, 8'd255, 0);
    for (int i = 0; i < 600; i++) begin
      step(1, 0, 8'd0, 0);
      if (obs !== expv()) begin errors++; $display("FAIL n255 cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
    end
    step(1, 1, 8'd2, 0);
    for (int i = 0; i < 280; i++) begin
      step(1, 0, 8'd0, 0);
      if (obs !== expv()) begin errors++; $display("FAIL n2 cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
`ifdef CLKDIV_TICK_EN
      if (i > 260) begin
        if (div_cur !== 8'd2 || tick_obs === prev_t) begin errors++; $display("FAIL tick_alt cyc=%0d tick=%b prev=%b n=%0d", cyc, tick_obs, prev_t, div_cur); end
        checks++;
      end
`endif
      prev_t = tick_obs;
    end
  endtask

  task automatic test_random();
    bit e, ld, r;
    logic [7:0] d;
    for (int i = 0; i < 2500; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 499) == 0);
      case ($urandom_range(0, 7))
        0:       d = 8'($urandom_range(0, 1));
        1:       d = 8'($urandom_range(2, 255));
        default: d = 8'($urandom_range(2, 12));
      endcase
      step(e, ld, d, r);
      if (obs !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv()); end
      checks++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default();
    test_load_mid();
    test_bad_load();
    test_freeze();
    test_back_to_back();
    test_rst_pending();
    test_extremes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider for generating slow strobes and peripheral clocks inside the fabric.
- Divides `clk` by any integer N from 2 to 2^CNT_W−1.
- Output duty cycle is as close to 50% as an integer count allows.
- Supports enable/freeze and glitch-free divisor changes at period boundaries.
- Replaces fixed power-of-two dividers wherever the ratio must be set by software or by other blocks.

## Interface
Parameters:
- CNT_W, 8: width of the counter and divisor.
- DEF_DIV, 64: divisor loaded at reset. Must be in 2..2^CNT_W−1.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; 0 freezes the counter and the output level.
- div_in  in  CNT_W  new divisor value.
- div_load  in  1  single-cycle request to load div_in.
- div_pend  out  1  a loaded divisor is waiting for the next period boundary.
- load_err  out  1  one-cycle pulse: the load was rejected (div_in < 2).
- div_cur  out  CNT_W  divisor currently in effect.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle strobe at each period start (only with CLKDIV_TICK_EN).

## Operation
- State: counter cnt, active divisor N, shadow register, pending flag. Define H = (N+1)>>1.
- Reset values: cnt=0, N=div_cur=DEF_DIV, shadow=0, div_pend=0, clk_out=0, load_err=0, tick=0.
- Counting, when en=1:
  - If cnt==N−1, cnt goes to 0.
  - Otherwise cnt goes to cnt+1.
  - cnt is 0 at the end of each period.
- Output: clk_out is registered as (1 ≤ cnt_next ≤ H).
  - High for H cycles, low for N−H cycles.
  - Even N gives exactly 50% duty; odd N is high for one extra cycle.
- Period boundary: the en=1 edge where cnt goes from 0 to 1.
  - If div_pend is set, then on that edge N ← shadow and div_pend ← 0.
  - cnt_next compares against the new H on that same edge.
- Load:
  - div_load with div_in ≥ 2: shadow ← div_in, div_pend ← 1.
  - div_load with div_in < 2: shadow and div_pend are unchanged, load_err pulses.
- Load on the same cycle as a boundary: the old shadow is applied to N. The new div_in goes into shadow and div_pend stays 1.
- Back-to-back loads: the last accepted value wins.
- en=0: cnt, clk_out and N hold. Loads are still accepted; they are applied at the first boundary after en returns to 1.
- Reset mid-period: all state returns to reset values on the next edge and any pending load is discarded.

## Timing
- First enabled edge after reset: clk_out rises.
- tick (when configured) is asserted on the same edge as every clk_out rise.
- Divisor change latency: 1 to N_old cycles, ending at the next boundary. No period is ever truncated or stretched.
- load_err is registered and asserted on the edge after the rejected div_load.
- div_pend rises on the edge after div_load.
- div_cur updates on the boundary edge.
- The counter never exceeds N−1. Wrap-around at N = 2^CNT_W−1 uses no overflow bit.

## Configuration
- CLKDIV_TICK_EN defined:
  - tick port and its register are present.
  - tick = 1 for exactly one cycle per period, on the edge where cnt_next==1.
- CLKDIV_TICK_EN undefined:
  - tick port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package clkdiv_pkg holds:
  - the minimum divisor constant (2);
  - a function computing H from N;
  - default parameter values.
- One sub-module, clkdiv_shadow, holds:
  - the shadow register and pending flag;
  - the validation that generates load_err;
  - the apply-at-boundary handshake.
- The top level holds the counter, the compare and the output registers.

## Test plan
- Reset, en=1, DEF_DIV=64 → clk_out high 32 cycles, low 32 cycles, repeating; div_cur=64.
- Load 5 mid-period → div_pend=1 until the boundary, then the pattern is high 3, low 2; the old period completes a full 64 cycles.
- Load 0 and load 1 → load_err pulses each time; div_pend=0; div_cur unchanged.
- en=0 for 10 cycles while clk_out is high → clk_out and cnt hold; the period resumes with no lost or extra cycles.
- Load 7 then load 9 on consecutive cycles, then a boundary → div_cur=9; period 9 (high 5, low 4).
- rst asserted mid-period with a load pending → the next cycle shows reset values; the pending value is never applied.
- With CLKDIV_TICK_EN, N=2 → tick=1 on every other cycle, aligned with clk_out rising.
